// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32 control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP) with mem_ready stall.
// Define MC_CTRL_PERF_EN to build the retire/cycle performance counters; otherwise they read 0.
module mc_ctrl_fsm #(
    parameter int ALU_CC_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem2reg,
    output logic                alu_src,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ALU_CC_W-1:0] alu_cc,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [CNT_W-1:0]    retire_cnt,
    output logic [CNT_W-1:0]    cycle_cnt
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;
    typedef enum logic [1:0] {C_R, C_I, C_LW, C_SW} cls_t;

    state_t                state_q, state_d;
    cls_t                  cls_q, cls_d;
    logic [ALU_CC_W-1:0]   cc_q, cc_d;
    logic                  bad, retire;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? 4'b0110 : 4'b0010;
            3'b001:  alu_op = 4'b0100;
            3'b010:  alu_op = 4'b0111;
            3'b011:  alu_op = 4'b1000;
            3'b100:  alu_op = 4'b0011;
            3'b101:  alu_op = alt ? 4'b1001 : 4'b0101;
            3'b110:  alu_op = 4'b0001;
            default: alu_op = 4'b0000;
        endcase
    endfunction

    // Decode is only consumed in DECODE; its results are latched so no output sees the instruction bits.
    always_comb begin
        cls_d = C_R;
        cc_d  = ALU_CC_W'(4'b0010);
        bad   = 1'b0;
        case (opcode)
            7'b0110011: begin
                cls_d = C_R;
                cc_d  = ALU_CC_W'(alu_op(funct3, funct7 == 7'b0100000));
                bad   = !(funct7 == 7'b0000000 ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            7'b0010011: begin
                cls_d = C_I;
                cc_d  = ALU_CC_W'(alu_op(funct3, funct3 == 3'b101 && funct7 == 7'b0100000));
            end
            7'b0000011: cls_d = C_LW;
            7'b0100011: cls_d = C_SW;
            default:    bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = bad ? TRAP : EXEC;
            EXEC:    state_d = (cls_q == C_R || cls_q == C_I) ? WB : MEM;
            MEM:     state_d = !mem_ready ? MEM : (cls_q == C_LW) ? WB : FETCH;
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cls_q   <= C_R;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                cls_q <= cls_d;
                cc_q  <= bad ? '0 : cc_d;
            end
        end
    end

    // Strobes are gated by reset so an abort drops them in the same cycle.
    always_comb begin
        retire    = state_q == WB || (state_q == MEM && mem_ready && cls_q == C_SW);
        pc_write  = reset && retire;
        ir_write  = reset && state_q == FETCH;
        reg_write = reset && state_q == WB;
        mem2reg   = reset && state_q == WB && cls_q == C_LW;
        alu_src   = reset && state_q == EXEC && cls_q != C_R;
        mem_read  = reset && state_q == MEM && cls_q == C_LW;
        mem_write = reset && state_q == MEM && cls_q == C_SW;
        alu_cc    = (reset && state_q == EXEC) ? cc_q : '0;
        illegal   = state_q == TRAP;
        state     = state_q;
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] ret_q, cyc_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_q <= '0;
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (pc_write) ret_q <= ret_q + CNT_W'(1);
        end
    end
    assign retire_cnt = ret_q;
    assign cycle_cnt  = cyc_q;
`else
    assign retire_cnt = '0;
    assign cycle_cnt  = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed instruction stream checked every cycle against a per-instruction expected-cycle model.
module tb_mc_ctrl_fsm;
`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LW_OP = 7'b0000011, SW_OP = 7'b0100011;

    logic        clk = 1'b0, reset = 1'b0, mem_ready = 1'b0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic        pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write, illegal;
    logic [3:0]  alu_cc;
    logic [2:0]  state;
    logic [31:0] retire_cnt, cycle_cnt;

    mc_ctrl_fsm #(.ALU_CC_W(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem2reg(mem2reg), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .alu_cc(alu_cc), .state(state), .illegal(illegal), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ir, pc, rw, m2r, src, rd, wr;
        logic [3:0]  cc;
        logic        ill;
        logic [31:0] ret, cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   m_ret = 0, m_cyc = 0;

    task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [14:0] act_ctl();
        return {state, ir_write, pc_write, reg_write, mem2reg, alu_src, mem_read, mem_write, alu_cc, illegal};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctl", 64'(act_ctl()), 64'({e.st, e.ir, e.pc, e.rw, e.m2r, e.src, e.rd, e.wr, e.cc, e.ill}));
            chk("retire_cnt", 64'(retire_cnt), PERF ? 64'(e.ret) : 64'd0);
            chk("cycle_cnt", 64'(cycle_cnt), PERF ? 64'(e.cyc) : 64'd0);
        end
    end

    task automatic push(exp_t e);
        e.ret = m_ret;
        e.cyc = m_cyc;
        q.push_back(e);
        m_cyc++;
        if (e.pc) m_ret++;
    endtask

    // One instruction: FETCH, DECODE, EXEC, (w+1) MEM cycles for memory ops, WB except for SW; illegal holds TRAP 20 cycles.
    task automatic run(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, int w, logic [3:0] cc, bit ill, int lim);
        exp_t e;
        bit lw, sw, mem;
        int n;
        lw = op == LW_OP; sw = op == SW_OP; mem = lw | sw;
        e = '0; e.st = 3'd0; e.ir = 1'b1; push(e);
        e = '0; e.st = 3'd1; push(e);
        if (ill) begin
            for (int k = 0; k < 20; k++) begin e = '0; e.st = 3'd5; e.ill = 1'b1; push(e); end
        end else begin
            e = '0; e.st = 3'd2; e.cc = cc; e.src = op != R_OP; push(e);
            if (mem)
                for (int k = 0; k <= w; k++) begin
                    e = '0; e.st = 3'd3; e.rd = lw; e.wr = sw; e.pc = sw && k == w; push(e);
                end
            if (!sw) begin e = '0; e.st = 3'd4; e.rw = 1'b1; e.pc = 1'b1; e.m2r = lw; push(e); end
        end
        if (lim > 0) while (q.size() > lim) void'(q.pop_back());
        n = q.size();
        opcode = op; funct3 = f3; funct7 = f7;
        for (int c = 0; c < n; c++) begin
            mem_ready = !(mem && c >= 3 && c < 3 + w);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(int n);
        reset = 1'b0;
        #2;
        chk("rst_ctl", 64'(act_ctl()), 64'd0);
        chk("rst_ret", 64'(retire_cnt), 64'd0);
        chk("rst_cyc", 64'(cycle_cnt), 64'd0);
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        m_ret = 0; m_cyc = 0;
        reset = 1'b1;
    endtask

    initial begin
        do_reset(3);
        run(R_OP, 3'b000, 7'b0000000, 0, 4'b0010, 1'b0, 0);
        chk("ret_after_add", 64'(retire_cnt), PERF ? 64'd1 : 64'd0);
        chk("cyc_after_add", 64'(cycle_cnt), PERF ? 64'd4 : 64'd0);
        run(LW_OP, 3'b010, 7'b0000000, 3, 4'b0010, 1'b0, 0);
        chk("cyc_after_lw", 64'(cycle_cnt), PERF ? 64'd12 : 64'd0);
        run(SW_OP, 3'b010, 7'b0000000, 0, 4'b0010, 1'b0, 0);
        chk("cyc_after_sw", 64'(cycle_cnt), PERF ? 64'd16 : 64'd0);
        run(R_OP, 3'b101, 7'b0100000, 0, 4'b1001, 1'b0, 0);
        run(R_OP, 3'b000, 7'b0100000, 0, 4'b0110, 1'b0, 0);
        run(R_OP, 3'b011, 7'b0000000, 0, 4'b1000, 1'b0, 0);
        run(R_OP, 3'b100, 7'b0000000, 0, 4'b0011, 1'b0, 0);
        run(R_OP, 3'b001, 7'b0000000, 0, 4'b0100, 1'b0, 0);
        run(I_OP, 3'b101, 7'b0100000, 0, 4'b1001, 1'b0, 0);
        run(I_OP, 3'b101, 7'b0000000, 0, 4'b0101, 1'b0, 0);
        run(I_OP, 3'b000, 7'b0100000, 0, 4'b0010, 1'b0, 0);
        run(I_OP, 3'b110, 7'b1111111, 0, 4'b0001, 1'b0, 0);
        run(SW_OP, 3'b010, 7'b0000000, 2, 4'b0010, 1'b0, 0);
        chk("ret_after_mix", 64'(retire_cnt), PERF ? 64'd13 : 64'd0);
        // Stalled LW aborted by reset while in MEM.
        run(LW_OP, 3'b010, 7'b0000000, 6, 4'b0010, 1'b0, 5);
        mem_ready = 1'b0;
        #2;
        chk("stall_mem_read", 64'(mem_read), 64'd1);
        chk("stall_state", 64'(state), 64'd3);
        reset = 1'b0;
        #1;
        chk("abort_mem_read", 64'(mem_read), 64'd0);
        chk("abort_state", 64'(state), 64'd0);
        chk("abort_ret", 64'(retire_cnt), 64'd0);
        @(posedge clk); #1;
        q.delete();
        m_ret = 0; m_cyc = 0;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) run(R_OP, 3'b000, 7'b0000000, 0, 4'b0010, 1'b0, 0);
        chk("ret_10_adds", 64'(retire_cnt), PERF ? 64'd10 : 64'd0);
        chk("cyc_10_adds", 64'(cycle_cnt), PERF ? 64'd40 : 64'd0);
        run(R_OP, 3'b000, 7'b0000001, 0, 4'b0000, 1'b1, 0);
        chk("trap_illegal", 64'(illegal), 64'd1);
        chk("trap_ret", 64'(retire_cnt), PERF ? 64'd10 : 64'd0);
        do_reset(2);
        run(7'b1101111, 3'b000, 7'b0000000, 0, 4'b0000, 1'b1, 0);
        do_reset(1);
        run(LW_OP, 3'b010, 7'b0000000, 0, 4'b0010, 1'b0, 0);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
